channel_write_arbiter: RTL and testbench
========================================

# channel_write_arbiter

Round-robin arbiter that shares one downstream channel write port among four HLS-generated producers (e.g. several reduce kernels feeding a single result channel). A producer holds the grant for a burst of up to MAX_BURST accepted words or until it drops its write valid, then the grant rotates. Data and valid pass through combinationally once granted. Arbitration costs one cycle per grant.

## Interface
- WIDTH, 32: channel data width.
- MAX_BURST, 4: maximum words accepted per grant, range 1..255.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- req0_in_data .. req3_in_data  input  WIDTH  producer write data.
- req0_write_valid .. req3_write_valid  input  1  producer has a word to write.
- req0_write_ready .. req3_write_ready  output  1  word accepted this cycle.
- out_in_data  output  WIDTH  data to the shared channel.
- out_write_valid  output  1  write strobe to the shared channel.
- out_write_ready  input  1  shared channel can accept a word.
- grant  output  4  one-hot current owner; 0 when idle.
- busy  output  1  high while in GRANT.

## Operation
- State registers: state (IDLE/GRANT), grant[3:0], rr_ptr[1:0] (highest-priority index), beat_cnt[7:0].
- IDLE:
  - If any reqN_write_valid is high, select the first asserting index scanning rr_ptr, rr_ptr+1, … mod 4.
  - Register grant (one-hot) and clear beat_cnt; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, with g the granted index:
  - out_write_valid = req{g}_write_valid; out_in_data = req{g}_in_data.
  - req{g}_write_ready = out_write_ready; all other write_ready are 0.
  - A beat is accepted when req{g}_write_valid & out_write_ready.
  - On an accepted beat, beat_cnt increments.
  - Release occurs at the edge when either:
    - an accepted beat brings beat_cnt to MAX_BURST; or
    - req{g}_write_valid is 0 in that cycle.
  - On release: grant ← 0, rr_ptr ← g+1 mod 4, state ← IDLE.
- Outside GRANT:
  - out_write_valid = 0 and out_in_data = 0.
  - All write_ready are 0.
  - busy = 0.
- A producer waiting on a deasserted out_write_ready keeps the grant; no timeout.
- Ungranted producers are never acked. Their data is ignored and must be held by the producer (channel semantics).

## Timing
- Reset: applies immediately and asynchronously, mid-burst included.
  - State: IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0.
  - Outputs: out_write_valid = 0, out_in_data = 0, all write_ready = 0, busy = 0.
  - A beat in flight at reset is not accepted.
- Latency, idle to first possible accept: 1 cycle.
  - A request seen at edge k gives grant/busy high after edge k.
  - First accept can occur in cycle k+1.
- Throughput:
  - Up to 1 word/cycle inside a grant.
  - MAX_BURST words per MAX_BURST+1 cycles under saturation, because of the one IDLE cycle per grant.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… Each requester waits at most 3 bursts.
- Simultaneous release and new requests: release always returns to IDLE for one cycle. No back-to-back grant without the IDLE cycle.
- MAX_BURST = 1: every accepted beat releases.
- Valid must not depend on write_ready (no combinational loop). The arbiter's ready depends on out_write_ready and registered grant only.

## Test plan
- Reset/idle: assert rst mid-cycle with req1 granted and out_write_ready = 1.
  - Outputs drop to 0 without waiting for a clock edge.
  - After release, req2 alone requesting is granted first (rr_ptr = 0, scan finds index 2).
- Single requester burst, MAX_BURST = 4: req0 valid with data 0x10..0x15 and out_write_ready = 1 throughout.
  - Accepts 0x10–0x13 in cycles 1–4.
  - IDLE in cycle 5; regrant to req0; 0x14 accepted in cycle 6.
- All four requesting continuously, each streaming its own index in the data:
  - Output sequence is four words of 0, then four of 1, then of 2, then of 3, then 0 again.
  - One idle cycle between groups.
- Back-pressure: req2 granted, out_write_ready low for 5 cycles.
  - grant stays 0100 and req2_write_ready stays 0.
  - beat_cnt is unchanged.
  - Burst completes after ready returns.
- Early release: req3 granted, 2 beats accepted, then req3_write_valid drops.
  - Release at that edge; rr_ptr = 0.
  - Pending req0 is granted next.
- Ready isolation: req0 and req1 both valid, req0 granted, out_write_ready = 1.
  - req1_write_ready stays 0 throughout req0's burst.
  - No req1 data appears on out_in_data.

Source files
------------

// File: rtl/channel_write_arbiter.sv
// Four-producer round-robin arbiter sharing one channel write port.
// A grant lasts up to MAX_BURST accepted words or until the owner drops valid.
module channel_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req0_in_data,
    input  logic [WIDTH-1:0] req1_in_data,
    input  logic [WIDTH-1:0] req2_in_data,
    input  logic [WIDTH-1:0] req3_in_data,
    input  logic             req0_write_valid,
    input  logic             req1_write_valid,
    input  logic             req2_write_valid,
    input  logic             req3_write_valid,
    output logic             req0_write_ready,
    output logic             req1_write_ready,
    output logic             req2_write_ready,
    output logic             req3_write_ready,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_write_valid,
    input  logic             out_write_ready,
    output logic [3:0]       grant,
    output logic             busy
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state;
    logic [3:0] r_grant;
    logic [1:0] r_gidx;
    logic [1:0] r_rr_ptr;
    logic [7:0] r_beat_cnt;

    logic [3:0]       w_valid;
    logic [WIDTH-1:0] w_data [4];
    logic             w_sel_valid;
    logic             w_accept;
    logic             w_release;
    logic [7:0]       w_cnt_next;
    logic             w_found;
    logic [1:0]       w_pick;

    assign w_valid = {req3_write_valid, req2_write_valid, req1_write_valid, req0_write_valid};
    assign w_data[0] = req0_in_data;
    assign w_data[1] = req1_in_data;
    assign w_data[2] = req2_in_data;
    assign w_data[3] = req3_in_data;

    // Round-robin scan starting at the highest-priority index.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = 2'd0;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = 0; i < 4; i++) begin
            v_idx = r_rr_ptr + 2'(i);
            if (!w_found && w_valid[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    assign busy        = (r_state == S_GRANT);
    assign grant       = r_grant;
    assign w_sel_valid = busy & w_valid[r_gidx];
    assign w_accept    = w_sel_valid & out_write_ready;
    assign w_cnt_next  = r_beat_cnt + 8'd1;
    assign w_release   = busy & (!w_sel_valid || (w_accept && (w_cnt_next == 8'(MAX_BURST))));

    // Ready is built only from registered grant and downstream ready, so no loop through valid.
    assign req0_write_ready = r_grant[0] & out_write_ready;
    assign req1_write_ready = r_grant[1] & out_write_ready;
    assign req2_write_ready = r_grant[2] & out_write_ready;
    assign req3_write_ready = r_grant[3] & out_write_ready;
    assign out_write_valid  = w_sel_valid;
    assign out_in_data      = busy ? w_data[r_gidx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'd0;
            r_gidx     <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_beat_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_GRANT;
                        r_grant    <= 4'b0001 << w_pick;
                        r_gidx     <= w_pick;
                        r_beat_cnt <= 8'd0;
                    end
                end
                S_GRANT: begin
                    if (w_accept)
                        r_beat_cnt <= w_cnt_next;
                    if (w_release) begin
                        r_state  <= S_IDLE;
                        r_grant  <= 4'd0;
                        r_rr_ptr <= r_gidx + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_write_arbiter.sv
// Directed bench for channel_write_arbiter: producer FIFOs drive the requesters,
// and every word seen on the shared channel is checked against a scoreboard.
module tb_channel_write_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       v;
    logic [WIDTH-1:0] d [4];
    logic [3:0]       rdy;
    logic [WIDTH-1:0] out_in_data;
    logic             out_write_valid;
    logic             out_write_ready;
    logic [3:0]       grant;
    logic             busy;

    always #5 clk = ~clk;

    channel_write_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0_in_data(d[0]), .req1_in_data(d[1]), .req2_in_data(d[2]), .req3_in_data(d[3]),
        .req0_write_valid(v[0]), .req1_write_valid(v[1]),
        .req2_write_valid(v[2]), .req3_write_valid(v[3]),
        .req0_write_ready(rdy[0]), .req1_write_ready(rdy[1]),
        .req2_write_ready(rdy[2]), .req3_write_ready(rdy[3]),
        .out_in_data(out_in_data), .out_write_valid(out_write_valid),
        .out_write_ready(out_write_ready), .grant(grant), .busy(busy)
    );

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] mem [4][16];
    int               head [4];
    int               tail [4];
    logic [3:0]       acc;
    logic             rdy_next;
    logic [WIDTH-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int r, input logic [WIDTH-1:0] w);
        mem[r][tail[r]] = w;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            v[i] = (head[i] < tail[i]);
            d[i] = v[i] ? mem[i][head[i]] : '0;
        end
        out_write_ready = rdy_next;
    endtask

    // Runs at the falling edge: records accepts and checks channel words.
    task automatic sample();
        acc = v & rdy;
        chk("rdy_outside_grant", {60'd0, rdy & ~grant}, 64'd0);
        if (out_write_valid && out_write_ready) begin
            if (sb.size() == 0)
                chk("sb_unexpected_word", {32'd0, out_in_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("sb_data", {32'd0, out_in_data}, {32'd0, sb.pop_front()});
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acc[i]) head[i]++;
        drive();
    endtask

    task automatic cyc();
        adv();
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rdy_next = 1'b0;
        acc      = 4'd0;
        sb.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        sample();
    endtask

    task automatic drain();
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            cyc();
            n++;
            done = !busy && (v == 4'd0) && (acc == 4'd0);
        end
        chk("drain_timeout", {63'd0, done}, 64'd1);
        chk("sb_leftover", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [9:0] busy_exp;
        int         cnt;
        int         rem;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rdy_next = 1'b0;
        acc      = 4'd0;
        drive();
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_grant", {60'd0, grant}, 64'd0);
        chk("reset_ovalid", {63'd0, out_write_valid}, 64'd0);

        // Asynchronous reset in the middle of req1's burst.
        do_reset();
        load(1, 32'h60); load(1, 32'h61); load(1, 32'h62);
        sb.push_back(32'h60);
        rdy_next = 1'b1;
        cyc();
        chk("rst_t_idle_busy", {63'd0, busy}, 64'd0);
        cyc();
        chk("rst_t_grant1", {60'd0, grant}, 64'h2);
        adv();
        #1;
        chk("rst_t_inflight_rdy", {60'd0, rdy}, 64'h2);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", {63'd0, busy}, 64'd0);
        chk("rst_async_grant", {60'd0, grant}, 64'd0);
        chk("rst_async_rdy", {60'd0, rdy}, 64'd0);
        chk("rst_async_ovalid", {63'd0, out_write_valid}, 64'd0);
        chk("rst_async_odata", {32'd0, out_in_data}, 64'd0);
        chk("rst_sb_inflight_dropped", 64'(sb.size()), 64'd0);
        do_reset();
        load(2, 32'h70);
        sb.push_back(32'h70);
        rdy_next = 1'b1;
        cyc();
        cyc();
        chk("rst_then_req2_grant", {60'd0, grant}, 64'h4);
        drain();

        // Single requester, bursts of four with one idle cycle between grants.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            load(0, 32'h10 + k);
            sb.push_back(32'h10 + k);
        end
        rdy_next = 1'b1;
        busy_exp = 10'b0_1110_1111_0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk($sformatf("single_busy_c%0d", c), {63'd0, busy}, {63'd0, busy_exp[c]});
            if (c == 5) begin
                chk("single_idle_ovalid", {63'd0, out_write_valid}, 64'd0);
                chk("single_idle_odata", {32'd0, out_in_data}, 64'd0);
            end
        end
        chk("single_sb_done", 64'(sb.size()), 64'd0);

        // All four streaming continuously: 4x0,4x1,4x2,4x3, twice; 40 cycles total.
        do_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++) begin
                    load(r, 32'(r));
                    sb.push_back(32'(r));
                end
        rdy_next = 1'b1;
        cnt = 0;
        rem = 32;
        while (rem != 0 && cnt < 100) begin
            cyc();
            cnt++;
            rem = 0;
            for (int i = 0; i < 4; i++)
                rem += tail[i] - head[i] - int'(acc[i]);
        end
        chk("rr_cycle_count", 64'(cnt), 64'd40);
        drain();

        // Back-pressure on req2: grant held, beat count preserved.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            load(2, 32'h20 + k);
            sb.push_back(32'h20 + k);
        end
        rdy_next = 1'b1;
        cyc();
        cyc();
        chk("bp_first_accept", {60'd0, rdy}, 64'h4);
        rdy_next = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("bp_grant_c%0d", c), {60'd0, grant}, 64'h4);
            chk($sformatf("bp_rdy2_c%0d", c), {63'd0, rdy[2]}, 64'd0);
        end
        rdy_next = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("bp_resume_rdy2_c%0d", c), {63'd0, rdy[2]}, 64'd1);
        end
        cyc();
        chk("bp_release_on_count", {63'd0, busy}, 64'd0);
        drain();

        // Early release by req3, pointer wraps so req0 wins over req1.
        do_reset();
        load(3, 32'h30); load(3, 32'h31);
        sb.push_back(32'h30); sb.push_back(32'h31);
        sb.push_back(32'h40); sb.push_back(32'h50);
        rdy_next = 1'b1;
        cyc();
        load(0, 32'h40);
        load(1, 32'h50);
        cyc();
        chk("early_grant3", {60'd0, grant}, 64'h8);
        cyc();
        cyc();
        chk("early_valid_drop_busy", {63'd0, busy}, 64'd1);
        chk("early_valid_drop_ov", {63'd0, out_write_valid}, 64'd0);
        cyc();
        chk("early_idle", {63'd0, busy}, 64'd0);
        cyc();
        chk("early_next_grant0", {60'd0, grant}, 64'h1);
        drain();

        // Ready isolation: req1 never acked during req0's burst.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(0, 32'hA0 + k);
            load(1, 32'hB0 + k);
            sb.push_back(32'hA0 + k);
        end
        for (int k = 0; k < 4; k++)
            sb.push_back(32'hB0 + k);
        rdy_next = 1'b1;
        cyc();
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("iso_grant0_c%0d", c), {60'd0, grant}, 64'h1);
            chk($sformatf("iso_rdy1_c%0d", c), {63'd0, rdy[1]}, 64'd0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
